// File: rtl/tile_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tile_scheduler_pkg
// Description : Shared tile geometry, ceil-div shift amounts and the one-hot
//               state encoding for the tile scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package tile_scheduler_pkg;

    // Output tile geometry: one 8x8 array tall, two 8x8 arrays wide
    localparam int unsigned c_TILE_M  = 8;
    localparam int unsigned c_TILE_P  = 16;
    localparam int unsigned c_DIM_W   = 16;

    // ceil(x / TILE) is computed as (x + TILE - 1) >> SHIFT
    localparam int unsigned c_M_SHIFT = $clog2(c_TILE_M);
    localparam int unsigned c_P_SHIFT = $clog2(c_TILE_P);

    // One-hot scheduler states
    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_CALC  = 6'b000010,
        ST_ISSUE = 6'b000100,
        ST_BUSY  = 6'b001000,
        ST_DRAIN = 6'b010000,
        ST_DONE  = 6'b100000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tile_scheduler_counter.sv
`default_nettype none
// ============================================================================
// Module      : tile_scheduler_counter
// Description : Two-level tile counter. pt is the inner (column) index, mt
//               the outer (row) index. Remaining rows/cols of the current
//               tile position are tracked so tile sizes need no multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_scheduler_counter
    import tile_scheduler_pkg::*;
#(
    parameter int unsigned DIM_W  = c_DIM_W,
    parameter int unsigned TILE_M = c_TILE_M,
    parameter int unsigned TILE_P = c_TILE_P
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_advance,
    input  logic [DIM_W-1:0] i_m_dim,
    input  logic [DIM_W-1:0] i_p_dim,
    input  logic [DIM_W-1:0] i_mt_total,
    input  logic [DIM_W-1:0] i_pt_total,
    output logic [DIM_W-1:0] o_mt,
    output logic [DIM_W-1:0] o_pt,
    output logic [DIM_W-1:0] o_mrem,
    output logic [DIM_W-1:0] o_prem,
    output logic             o_last_p,
    output logic             o_last_m
);

    logic [DIM_W-1:0] r_mt;
    logic [DIM_W-1:0] r_pt;
    logic [DIM_W-1:0] r_mrem;
    logic [DIM_W-1:0] r_prem;
    logic             w_last_p;
    logic             w_last_m;

    // Last-position flags for the inner and outer loop
    always_comb begin
        w_last_p = (r_pt == (i_pt_total - DIM_W'(1)));
        w_last_m = (r_mt == (i_mt_total - DIM_W'(1)));
    end

    // Row-major walk: step pt first, wrap it and step mt at the row end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mt   <= '0;
            r_pt   <= '0;
            r_mrem <= '0;
            r_prem <= '0;
        end else if (i_load) begin
            r_mt   <= '0;
            r_pt   <= '0;
            r_mrem <= i_m_dim;
            r_prem <= i_p_dim;
        end else if (i_advance) begin
            if (!w_last_p) begin
                r_pt   <= r_pt + DIM_W'(1);
                r_prem <= r_prem - DIM_W'(TILE_P);
            end else if (!w_last_m) begin
                r_pt   <= '0;
                r_prem <= i_p_dim;
                r_mt   <= r_mt + DIM_W'(1);
                r_mrem <= r_mrem - DIM_W'(TILE_M);
            end
        end
    end

    assign o_mt     = r_mt;
    assign o_pt     = r_pt;
    assign o_mrem   = r_mrem;
    assign o_prem   = r_prem;
    assign o_last_p = w_last_p;
    assign o_last_m = w_last_m;

endmodule
`default_nettype wire

// File: rtl/tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tile_scheduler
// Description : Splits an MxN * NxP int8 matmul into 8x16 output tiles,
//               launches Multiply_ctrl once per tile and hands each finished
//               tile to writeback over a valid/ready pair.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_scheduler
    import tile_scheduler_pkg::*;
#(
    parameter int unsigned TILE_M = c_TILE_M,
    parameter int unsigned TILE_P = c_TILE_P,
    parameter int unsigned DIM_W  = c_DIM_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] M,
    input  logic [DIM_W-1:0] N,
    input  logic [DIM_W-1:0] P,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       sub_M,
    output logic [7:0]       sub_P,
    output logic [DIM_W-1:0] N_out,
    output logic [DIM_W-1:0] subFM_addr,
    output logic [DIM_W-1:0] subFM_incr,
    output logic [DIM_W-1:0] subWM_addr,
    output logic [DIM_W-1:0] subWM_incr,
    output logic             submulti_start,
    input  logic             submulti_finish,
    output logic             wb_valid,
    output logic [DIM_W-1:0] wb_m_idx,
    output logic [DIM_W-1:0] wb_p_idx,
    input  logic             wb_ready
);

    localparam int unsigned M_SHIFT = $clog2(TILE_M);
    localparam int unsigned P_SHIFT = $clog2(TILE_P);

    state_t           r_state;
    state_t           w_next_state;

    logic [DIM_W-1:0] r_m;
    logic [DIM_W-1:0] r_n;
    logic [DIM_W-1:0] r_p;
    logic             r_err;
    logic [DIM_W-1:0] r_mt_total;
    logic [DIM_W-1:0] r_pt_total;

    logic             w_zero_dim;
    logic             w_load;
    logic             w_advance;
    logic [DIM_W-1:0] w_mt;
    logic [DIM_W-1:0] w_pt;
    logic [DIM_W-1:0] w_mrem;
    logic [DIM_W-1:0] w_prem;
    logic             w_last_p;
    logic             w_last_m;

    assign w_zero_dim = (M == '0) || (N == '0) || (P == '0);
    assign w_load     = (r_state == ST_CALC);
    assign w_advance  = (r_state == ST_DRAIN) && wb_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-state control outputs
    always_comb begin
        w_next_state   = r_state;
        busy           = 1'b1;
        done           = 1'b0;
        submulti_start = 1'b0;
        wb_valid       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = w_zero_dim ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                submulti_start = 1'b1;
                w_next_state   = ST_BUSY;
            end
            ST_BUSY: begin
                if (submulti_finish) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    w_next_state = (w_last_p && w_last_m) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the job on an accepted start; err restarts from the new dimensions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_n   <= '0;
            r_p   <= '0;
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_m   <= M;
            r_n   <= N;
            r_p   <= P;
            r_err <= w_zero_dim;
        end
    end

    // Tile counts via shift; the carry of the 17-bit sum keeps M=0xFFFF exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mt_total <= '0;
            r_pt_total <= '0;
        end else if (r_state == ST_CALC) begin
            r_mt_total <= DIM_W'(({1'b0, r_m} + (DIM_W+1)'(TILE_M - 1)) >> M_SHIFT);
            r_pt_total <= DIM_W'(({1'b0, r_p} + (DIM_W+1)'(TILE_P - 1)) >> P_SHIFT);
        end
    end

    tile_scheduler_counter #(
        .DIM_W  (DIM_W),
        .TILE_M (TILE_M),
        .TILE_P (TILE_P)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_advance  (w_advance),
        .i_m_dim    (r_m),
        .i_p_dim    (r_p),
        .i_mt_total (r_mt_total),
        .i_pt_total (r_pt_total),
        .o_mt       (w_mt),
        .o_pt       (w_pt),
        .o_mrem     (w_mrem),
        .o_prem     (w_prem),
        .o_last_p   (w_last_p),
        .o_last_m   (w_last_m)
    );

    // Tile size is the remainder clipped to the tile edge; counters only move
    // on the writeback handshake so these hold from one ISSUE to the next
    always_comb begin
        sub_M = (w_mrem >= DIM_W'(TILE_M)) ? 8'(TILE_M) : w_mrem[7:0];
        sub_P = (w_prem >= DIM_W'(TILE_P)) ? 8'(TILE_P) : w_prem[7:0];
    end

    assign err        = r_err;
    assign N_out      = r_n;
    assign subFM_addr = w_mt;
    assign subFM_incr = r_mt_total;
    assign subWM_addr = w_pt;
    assign subWM_incr = r_pt_total;
    assign wb_m_idx   = w_mt;
    assign wb_p_idx   = w_pt;

endmodule
`default_nettype wire
